// File: rtl/seg_display_arbiter_pkg.sv
// seg_display_arbiter_pkg: shared FSM state encodings and default hold time
package seg_display_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    localparam logic [23:0] HOLD_CYCLES = 24'd5_000_000;

endpackage

// File: rtl/seg_display_arbiter_rr_pick.sv
// seg_display_arbiter_rr_pick: combinational round-robin priority picker
// Ports:
//   req    - request vector
//   ptr    - index with highest priority this cycle
//   mask   - requesters excluded from selection
//   any    - at least one unmasked request
//   idx    - winning index (first set bit scanning upward from ptr, modulo n)
//   onehot - winner as a one-hot vector, zero when nothing wins
module seg_display_arbiter_rr_pick #(
    parameter int n     = 4,
    parameter int idx_w = 3
) (
    input  logic [n-1:0]     req,
    input  logic [idx_w-1:0] ptr,
    input  logic [n-1:0]     mask,
    output logic             any,
    output logic [idx_w-1:0] idx,
    output logic [n-1:0]     onehot
);

    logic [n-1:0] cand;

    assign cand   = req & ~mask;
    assign any    = |cand;
    assign onehot = any ? (n'(1) << idx) : '0;

    // Later assignments win: the lowest bit at or above ptr overrides the
    // lowest bit below ptr, giving the wrap-around scan order.
    always_comb begin
        idx = '0;
        for (int i = n - 1; i >= 0; i--)
            if (cand[i] && i < int'(ptr)) idx = idx_w'(i);
        for (int i = n - 1; i >= 0; i--)
            if (cand[i] && i >= int'(ptr)) idx = idx_w'(i);
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin sharing of the 7-segment display value with minimum hold
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-low reset
//   req    - level request per requester, held until its ack
//   data   - flattened requester values, requester i at [i*w +: w]
//   freeze - blocks new grants while high
//   ack    - one-cycle one-hot capture pulse
//   num    - registered display value
//   owner  - index of the requester currently shown
//   busy   - high while the minimum hold is running
module seg_display_arbiter
    import seg_display_arbiter_pkg::*;
#(
    parameter int               w           = 32,
    parameter int               n_req       = 4,
    parameter int               hold_w      = 24,
    parameter logic [hold_w-1:0] hold_cycles = hold_w'(HOLD_CYCLES),
    parameter int               idx_w       = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [n_req-1:0]   req,
    input  logic [n_req*w-1:0] data,
    input  logic               freeze,
    output logic [n_req-1:0]   ack,
    output logic [w-1:0]       num,
    output logic [idx_w-1:0]   owner,
    output logic               busy
);

    // A hold of 0 behaves as 1: the counter reloads with max(hold_cycles,1)-1.
    localparam logic [hold_w-1:0] hold_load = (hold_cycles == '0) ? '0 : hold_cycles - 1'b1;

    state_t             state, nxt;
    logic [idx_w-1:0]   ptr;
    logic [hold_w-1:0]  cnt;
    logic               any, grant;
    logic [idx_w-1:0]   idx;
    logic [n_req-1:0]   onehot;
    logic [w-1:0]       sel;

    // The previous cycle's ack masks that requester while it drops req.
    seg_display_arbiter_rr_pick #(
        .n     (n_req),
        .idx_w (idx_w)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr),
        .mask   (ack),
        .any    (any),
        .idx    (idx),
        .onehot (onehot)
    );

    assign busy = state == ST_HOLD;

    always_comb begin
        grant = state != ST_HOLD && !freeze && any;
        nxt   = grant ? ST_HOLD : (state == ST_HOLD && cnt == '0) ? ST_READY : state;
    end

    always_comb begin
        sel = '0;
        for (int i = 0; i < n_req; i++)
            if (idx == idx_w'(i)) sel = data[i*w +: w];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num   <= '0;
            owner <= '0;
            ack   <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            ack <= grant ? onehot : '0;
            if (grant) begin
                num   <= sel;
                owner <= idx;
                ptr   <= (idx == idx_w'(n_req - 1)) ? '0 : idx + 1'b1;
                cnt   <= hold_load;
            end else if (state == ST_HOLD && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: directed self-checking bench for seg_display_arbiter
module tb_seg_display_arbiter;

    logic         clk = 0;
    logic         reset = 0;
    logic [3:0]   req = '0;
    logic [127:0] data = '0;
    logic         freeze = 0;

    logic [3:0]  ack4, ack2, ack0;
    logic [31:0] num4, num2, num0;
    logic [2:0]  own4, own2, own0;
    logic        busy4, busy2, busy0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_display_arbiter #(.w(32), .n_req(4), .hold_w(24), .hold_cycles(24'd4), .idx_w(3)) u4 (
        .clk(clk), .reset(reset), .req(req), .data(data), .freeze(freeze),
        .ack(ack4), .num(num4), .owner(own4), .busy(busy4));

    seg_display_arbiter #(.w(32), .n_req(4), .hold_w(24), .hold_cycles(24'd2), .idx_w(3)) u2 (
        .clk(clk), .reset(reset), .req(req), .data(data), .freeze(freeze),
        .ack(ack2), .num(num2), .owner(own2), .busy(busy2));

    seg_display_arbiter #(.w(32), .n_req(4), .hold_w(24), .hold_cycles(24'd0), .idx_w(3)) u0 (
        .clk(clk), .reset(reset), .req(req), .data(data), .freeze(freeze),
        .ack(ack0), .num(num0), .owner(own0), .busy(busy0));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        req = '0;
        reset = 0;
        tick();
        reset = 1;
    endtask

    initial begin
        logic [1:0] ord [0:5];
        data = {32'h0000_D333, 32'h0000_1234, 32'h0000_ABCD, 32'h0000_C000};
        #2;
        chk("rst_num", num4, 32'h0);
        chk("rst_owner", 32'(own4), 32'd0);
        chk("rst_ack", 32'(ack4), 32'd0);
        chk("rst_busy", 32'(busy4), 32'd0);
        tick();

        // single grant, hold of 4
        reset = 1;
        req = 4'b0100;
        tick();
        chk("g1_ack", 32'(ack4), 32'h4);
        chk("g1_num", num4, 32'h1234);
        chk("g1_owner", 32'(own4), 32'd2);
        chk("g1_busy", 32'(busy4), 32'd1);
        req = '0;
        tick();
        chk("g1_ack_pulse", 32'(ack4), 32'd0);
        tick();
        tick();
        chk("g1_busy_3", 32'(busy4), 32'd1);
        tick();
        chk("g1_busy_4", 32'(busy4), 32'd0);
        chk("g1_num_kept", num4, 32'h1234);

        // freeze in READY
        freeze = 1;
        req = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("frz_ack", 32'(ack4), 32'd0);
            chk("frz_num", num4, 32'h1234);
        end
        freeze = 0;
        tick();
        chk("frz_rel_ack", 32'(ack4), 32'h2);
        chk("frz_rel_num", num4, 32'hABCD);
        chk("frz_rel_owner", 32'(own4), 32'd1);
        req = '0;

        // async reset mid-hold (counter at 3), then grant from pointer 0
        #1;
        reset = 0;
        #1;
        chk("arst_num", num4, 32'h0);
        chk("arst_busy", 32'(busy4), 32'd0);
        chk("arst_ack", 32'(ack4), 32'd0);
        chk("arst_owner", 32'(own4), 32'd0);
        tick();
        reset = 1;
        req = 4'b1010;
        tick();
        chk("arst_grant_ack", 32'(ack4), 32'h2);
        chk("arst_grant_owner", 32'(own4), 32'd1);

        // round robin with all requesting, hold of 2
        pulse_reset();
        req = 4'b1111;
        ord[0] = 2'd0; ord[1] = 2'd1; ord[2] = 2'd2; ord[3] = 2'd3; ord[4] = 2'd0;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("rr_ack", 32'(ack2), 32'(4'b0001 << ord[k]));
            chk("rr_owner", 32'(own2), 32'(ord[k]));
            chk("rr_num", num2, data[32*ord[k] +: 32]);
            if (k < 4) begin
                tick();
                chk("rr_gap1", 32'(ack2), 32'd0);
                chk("rr_busy", 32'(busy2), 32'd1);
                tick();
                chk("rr_gap2", 32'(ack2), 32'd0);
                tick();
            end
        end

        // single requester 3, repeated grants, pointer wraps
        pulse_reset();
        req = 4'b1000;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("r3_ack", 32'(ack2), 32'h8);
            chk("r3_owner", 32'(own2), 32'd3);
            tick();
            chk("r3_gap", 32'(ack2), 32'd0);
            tick();
            tick();
        end
        chk("r3_ack_last", 32'(ack2), 32'h8);
        req = 4'b1001;
        tick();
        tick();
        tick();
        chk("wrap_ack", 32'(ack2), 32'h1);
        chk("wrap_owner", 32'(own2), 32'd0);

        // hold of 0 behaves as 1: grant every 2 cycles
        pulse_reset();
        req = 4'b1111;
        ord[0] = 2'd0; ord[1] = 2'd1; ord[2] = 2'd2; ord[3] = 2'd3; ord[4] = 2'd0; ord[5] = 2'd1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("h0_ack", 32'(ack0), 32'(4'b0001 << ord[k]));
            chk("h0_owner", 32'(own0), 32'(ord[k]));
            chk("h0_busy", 32'(busy0), 32'd1);
            tick();
            chk("h0_gap", 32'(ack0), 32'd0);
            chk("h0_ready", 32'(busy0), 32'd0);
        end
        req = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
